// File: rtl/e203_dtcm_ram_arb_if.sv
// Command/response channel between one DTCM requester and the RAM arbiter.
// The requester drives the master side; the arbiter uses the slave side.
interface e203_dtcm_ram_arb_if #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int MW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/e203_dtcm_ram_arb.sv
// Round-robin arbiter sharing the single-port DTCM RAM between the LSU (a) and
// a loader/DMA path (b), with a one-deep response stage and light-sleep control.
module e203_dtcm_ram_arb #(
  parameter int AW      = 14,
  parameter int DW      = 32,
  parameter int MW      = 4,
  parameter int LS_IDLE = 16,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  e203_dtcm_ram_arb_if.slave a,
  e203_dtcm_ram_arb_if.slave b,
  output logic          dtcm_ram_cs,
  output logic          dtcm_ram_we,
  output logic [AW-1:0] dtcm_ram_addr,
  output logic [MW-1:0] dtcm_ram_wem,
  output logic [DW-1:0] dtcm_ram_din,
  input  logic [DW-1:0] dtcm_ram_dout,
  output logic          dtcm_ram_ls
);

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          prio_a_q, prio_a_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_b_q, rsp_b_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic          rsp_first_q, rsp_first_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          any_valid, rsp_hs, issue, gnt_a, gnt_b, gnt;
  logic          sel_read;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;
  logic [DW-1:0] rsp_data;

  assign any_valid = a.cmd_valid | b.cmd_valid;
  assign rsp_hs    = rsp_vld_q & (rsp_b_q ? b.rsp_ready : a.rsp_ready);
  // rst_n gating keeps the RAM pins quiet while reset is held, even with valid requests.
  assign issue     = rst_n & (state_q == ACTIVE) & (~rsp_vld_q | rsp_hs);
  assign gnt_a     = issue & a.cmd_valid & (~b.cmd_valid | prio_a_q);
  assign gnt_b     = issue & b.cmd_valid & (~a.cmd_valid | ~prio_a_q);
  assign gnt       = gnt_a | gnt_b;

  assign sel_read  = gnt_b ? b.cmd_read  : a.cmd_read;
  assign sel_addr  = gnt_b ? b.cmd_addr  : a.cmd_addr;
  assign sel_wdata = gnt_b ? b.cmd_wdata : a.cmd_wdata;
  assign sel_wmask = gnt_b ? b.cmd_wmask : a.cmd_wmask;

  assign a.cmd_ready    = gnt_a;
  assign b.cmd_ready    = gnt_b;
  assign dtcm_ram_cs    = gnt;
  assign dtcm_ram_we    = gnt & ~sel_read;
  assign dtcm_ram_addr  = gnt ? sel_addr : '0;
  assign dtcm_ram_wem   = (gnt & ~sel_read) ? sel_wmask : '0;
  assign dtcm_ram_din   = gnt ? sel_wdata : '0;
  assign dtcm_ram_ls    = (state_q == SLEEP);

  // RAM dout is only valid in the first response cycle; afterwards the hold copy is used.
  assign rsp_data     = (rsp_vld_q & rsp_rd_q) ? (rsp_first_q ? dtcm_ram_dout : hold_q) : '0;
  assign a.rsp_valid  = rsp_vld_q & ~rsp_b_q;
  assign b.rsp_valid  = rsp_vld_q & rsp_b_q;
  assign a.rsp_rdata  = rsp_b_q ? '0 : rsp_data;
  assign b.rsp_rdata  = rsp_b_q ? rsp_data : '0;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    case (state_q)
      ACTIVE: begin
        if (!any_valid && !rsp_vld_q) begin
          if (idle_cnt_q == CW'(LS_IDLE - 1)) state_d = SLEEP;
          else idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      SLEEP:   if (any_valid) state_d = WAKE;
      WAKE:    state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  always_comb begin
    rsp_vld_d   = rsp_vld_q;
    rsp_b_d     = rsp_b_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_first_d = gnt;
    prio_a_d    = prio_a_q;
    hold_d      = hold_q;
    if (rsp_first_q) hold_d = dtcm_ram_dout;
    if (rsp_hs) rsp_vld_d = 1'b0;
    if (gnt) begin
      rsp_vld_d = 1'b1;
      rsp_b_d   = gnt_b;
      rsp_rd_d  = sel_read;
      prio_a_d  = gnt_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACTIVE;
      idle_cnt_q  <= '0;
      prio_a_q    <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_b_q     <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      prio_a_q    <= prio_a_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_b_q     <= rsp_b_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_first_q <= rsp_first_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

endmodule

// File: doc/e203_dtcm_ram_arb.md
Name: e203_dtcm_ram_arb

Overview:
Two-requester arbiter and sequencer in front of the DTCM SRAM macro. It shares the single-port RAM between the core LSU (port A) and an external loader/DMA path (port B), and drives the RAM control pins cs/we/addr/wem/din. It returns read data with a registered response stage and manages the RAM light-sleep pin (ls) after a programmable idle period. It sits between the requester command/response channels and the DTCM RAM wrapper.

Parameters:
AW, 14, RAM word-address width
DW, 32, RAM data width
MW, 4, write-enable mask width (DW/8)
LS_IDLE, 16, consecutive idle cycles before asserting ls (>=2)
CW, 5, idle counter width (must hold LS_IDLE)

Ports:
clk  in  1  clock, same clock as the DTCM RAM
rst_n  in  1  asynchronous active-low reset
a_cmd_valid / b_cmd_valid  in  1  command request
a_cmd_ready / b_cmd_ready  out  1  command accepted this cycle
a_cmd_read / b_cmd_read  in  1  1=read, 0=write
a_cmd_addr / b_cmd_addr  in  AW  word address
a_cmd_wdata / b_cmd_wdata  in  DW  write data
a_cmd_wmask / b_cmd_wmask  in  MW  byte write mask
a_rsp_valid / b_rsp_valid  out  1  response valid
a_rsp_ready / b_rsp_ready  in  1  response accepted
a_rsp_rdata / b_rsp_rdata  out  DW  read data (0 for writes)
dtcm_ram_cs  out  1  RAM chip select
dtcm_ram_we  out  1  RAM write enable
dtcm_ram_addr  out  AW  RAM address
dtcm_ram_wem  out  MW  RAM byte mask
dtcm_ram_din  out  DW  RAM write data
dtcm_ram_dout  in  DW  RAM read data, valid the cycle after cs
dtcm_ram_ls  out  1  RAM light sleep

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all *_cmd_ready=0, *_rsp_valid=0, rsp_rdata=0, dtcm_ram_cs/we=0, addr/wem/din=0, ls=0. FSM=ACTIVE, idle_cnt=0, round-robin pointer favours A.
- FSM states: ACTIVE, SLEEP, WAKE.
- ACTIVE behaviour:
  - idle_cnt increments on each cycle with no cmd_valid and no response pending, and clears otherwise.
  - When idle_cnt reaches LS_IDLE-1 with no request, the FSM goes to SLEEP.
- SLEEP: ls=1 and both cmd_ready=0. Any cmd_valid moves the FSM to WAKE.
- WAKE: ls=0, cmd_ready=0 for exactly one cycle, then ACTIVE.
- Issue condition (ACTIVE only): the response stage is empty, or it is being handshaken this cycle. One outstanding access at most; throughput is one access per cycle.
- Arbitration:
  - Round-robin. If both requesters are valid, the one not granted last wins; if only one is valid, it wins.
  - The pointer updates only on an actual grant. The grant is combinational: cmd_ready is asserted for the winner only.
- RAM drive on a grant cycle:
  - cs=1, we=~read, addr/din/wem from the winner.
  - wem is forced to 0 on reads.
  - Outputs are combinational and gated to 0 when there is no grant.
- Response stage, set on grant:
  - rsp_vld=1, owner=winner, is_read recorded.
  - Latency: response valid exactly 1 cycle after the cmd handshake.
  - rdata = dtcm_ram_dout in the first response cycle. If not accepted, dout is latched into a hold register at that clock edge, and later cycles return the hold register.
  - Writes return rdata=0.
  - Only the owner sees rsp_valid; the other port's rsp_valid stays 0.
- Back-to-back accesses: response handshake and new grant in the same cycle are legal; the stage reloads with the new owner.
- Reset mid-operation: outstanding access dropped, response lost, FSM to ACTIVE; the requester must reissue.
- Requesters hold cmd fields stable while valid && !ready; the block does not check this.

Test Plan:
- Only A issues read at addr 0x0010, RAM returns 0xDEADBEEF -> cs=1/we=0/wem=0 in cycle 0; a_rsp_valid=1 with rdata 0xDEADBEEF in cycle 1; b_rsp_valid stays 0.
- A and B both valid every cycle, rsp_ready=1 -> grants alternate A,B,A,B; cs=1 every cycle; 8 responses in 8 cycles after a 1-cycle latency.
- A read, a_rsp_ready low for 3 cycles while dout changes to 0x1234 -> rdata stays at the first value; no new grant until the handshake; the next grant lands in the handshake cycle.
- B write 0xA5A5A5A5, mask 4'b0011, addr 0x3FFF -> we=1, wem=4'b0011, addr=0x3FFF; b_rsp_valid next cycle with rdata=0.
- No requests for 16 cycles -> ls=1 from cycle 16. A asserts valid -> ls=0 next cycle, one WAKE cycle with ready=0, then a_cmd_ready=1.
- rst_n asserted low while a response is pending -> all outputs 0 immediately; after release, arbitration favours A.
